// File: rtl/addsub_pkg.sv
// Shared constants and sizing helper for the pipelined adder/subtractor.
package addsub_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int cw(input int width, input int stages);
        return width / stages;
    endfunction
endpackage

// File: rtl/addsub_chunk.sv
// CW-bit combinational ripple adder slice: {co, s} = a + b + ci.
module addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);
    logic [CW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CW; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[CW];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: one CW-bit chunk per stage, operands skewed in, results deskewed out,
// so every chunk of a beat leaves together STAGES clocks after accept.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = cw(WIDTH, STAGES);

    logic                         adv;
    logic [STAGES:1]              vld_q;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:1]              cq;
    logic [STAGES-1:0]            co;
    logic [WIDTH-1:0]             b_in;
    logic                         c0;
    logic                         ovf_q;
    logic [STAGES-1:0][CW-1:0]    sum_c;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES];
    assign vld_pipe  = {vld_q, in_valid};

    assign b_in = (sub == MODE_SUB) ? ~b : b;
    assign c0   = (sub == MODE_SUB) ? 1'b1 : cin;

    always_ff @(posedge clock) begin
        if (rst) begin
            vld_q <= '0;
            cq    <= '0;
        end else if (adv) begin
            vld_q <= vld_pipe[STAGES-1:0];
            cq    <= co;
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        logic [CW-1:0]               op_a, op_b, s;
        logic                        ci;
        logic [STAGES-1-j:0][CW-1:0] sdk;

        if (j == 0) begin : g_in
            assign op_a = a[CW-1:0];
            assign op_b = b_in[CW-1:0];
            assign ci   = c0;
        end else begin : g_skew
            // Chunk j waits j clocks for the carry from the chunks below it.
            logic [j-1:0][CW-1:0] ask, bsk;

            always_ff @(posedge clock) begin
                if (rst) begin
                    ask <= '0;
                    bsk <= '0;
                end else if (adv) begin
                    ask[0] <= a[j*CW +: CW];
                    bsk[0] <= b_in[j*CW +: CW];
                    for (int i = 1; i < j; i++) begin
                        ask[i] <= ask[i-1];
                        bsk[i] <= bsk[i-1];
                    end
                end
            end

            assign op_a = ask[j-1];
            assign op_b = bsk[j-1];
            assign ci   = cq[j];
        end

        addsub_chunk #(.CW(CW)) u_chunk (
            .a  (op_a),
            .b  (op_b),
            .ci (ci),
            .s  (s),
            .co (co[j])
        );

        // Finished chunk rides along until the top chunk catches up.
        always_ff @(posedge clock) begin
            if (rst) begin
                sdk <= '0;
            end else if (adv) begin
                sdk[0] <= s;
                for (int i = 1; i <= STAGES-1-j; i++) sdk[i] <= sdk[i-1];
            end
        end

        assign sum_c[j] = sdk[STAGES-1-j];

        if (j == STAGES-1) begin : g_top
            always_ff @(posedge clock) begin
                if (rst)
                    ovf_q <= 1'b0;
                else if (adv)
                    ovf_q <= (op_a[CW-1] == op_b[CW-1]) & (s[CW-1] != op_a[CW-1]);
            end
        end
    end

    assign sum  = sum_c;
    assign cout = cq[STAGES];
    assign ovf  = ovf_q;
endmodule
